ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives the raw PS/2 keyboard lines (clock and data, asynchronous open-drain inputs), deframes 11-bit serial frames and decodes scan-code set 2 prefixes into the 11-bit `ps2_key` event word. This is the producing end of the `ps2_key` interface: toggle bit in [10], pressed in [9], extended in [8], code in [7:0]. Core input logic already consumes this word. It runs in the core's `clk_sys` domain and replaces the HPS-supplied `ps2_key` when a physical keyboard is wired to the user port.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized samples required before a line level is accepted (range 2–255).
- `TIMEOUT`, 2048: `clk_sys` cycles without a filtered clock falling edge before a partial frame is aborted (≥ 2 × FILTER_LEN).
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data line, asynchronous.
- `ps2_key`  out  11  event word {toggle, pressed, ext, code[7:0]}; a new event is signalled only by inversion of [10].
- `frame_err`  out  1  one-cycle pulse on a start, stop, parity or timeout error.
- `byte_stb`  out  1  one-cycle pulse for every good received byte, including prefixes.
- `byte_out`  out  8  last good byte; valid when `byte_stb` is high, held otherwise.

## Operation
- Line conditioning: each line is passed through a 2-flop synchronizer and then a FILTER_LEN run-length filter. The filtered output changes only after FILTER_LEN equal consecutive samples. The filtered clock falling edge (`fall`) is the sample strobe for data. The filtered idle level after reset is 1.
- Frame FSM:
  - RX_IDLE: on `fall`, if data = 0 (start bit), go to RX_SHIFT with bit count 0. If data = 1, the sample is a spurious start: ignore it and stay in RX_IDLE with no error.
  - RX_SHIFT: on each `fall`, shift data in LSB first, collecting 8 data bits, then parity, then stop. After the stop bit, go to RX_CHECK.
  - RX_CHECK: lasts one cycle. The frame is good when parity over data+parity is odd and stop = 1. A good frame pulses `byte_stb` and passes the byte to the decoder. A bad frame pulses `frame_err`. The FSM then returns to RX_IDLE.
- Watchdog: a counter runs in RX_SHIFT and is cleared on every `fall`. When it reaches TIMEOUT: pulse `frame_err`, go to RX_IDLE, clear the prefix flags. If `fall` and the timeout occur in the same cycle, `fall` wins.
- Byte decoder, applied to good bytes:
  - E0 sets `ext`.
  - F0 sets `brk`.
  - E1 loads `skip` = 7. While `skip` ≠ 0, each byte decrements it and is discarded, so the Pause sequence produces no event.
  - AA, FA, EE, FE, 00 and FF are discarded and the flags are left unchanged.
  - Any other byte sets `ps2_key` <= {~ps2_key[10], ~brk, ext, byte} and clears `ext` and `brk`.
- Any `frame_err` clears `ext`, `brk` and `skip`, and leaves `ps2_key` unchanged.

## Timing
- Reset values:
  - `ps2_key` = 11'h000, `frame_err` = 0, `byte_stb` = 0, `byte_out` = 8'h00.
  - FSM in RX_IDLE; `ext`, `brk`, `skip` and the watchdog cleared.
  - Filters and synchronizers at 1.
- Reset asserted mid-frame abandons the frame silently, with no `frame_err`.
- Latency:
  - Raw pin edge to `fall`: 2 + FILTER_LEN cycles.
  - Stop-bit `fall` to RX_CHECK: 1 cycle.
  - `byte_stb`/`frame_err` are high during RX_CHECK.
  - `ps2_key` is updated on the clock edge ending RX_CHECK, i.e. visible 2 cycles after the stop-bit `fall`.
- Events are at most one per frame, so a consumer sampling [10] once per cycle never misses a toggle.
- `byte_out` is updated in the same cycle that `byte_stb` is asserted.

## Structure
- Package `ps2_pkg`:
  - rx state enum {RX_IDLE, RX_SHIFT, RX_CHECK};
  - localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_PAUSE_LEN=7;
  - ignore-list constants.
- Sub-module `ps2_line_filter` (synchronizer + run-length filter, parameter FILTER_LEN, output level and fall pulse), instantiated once per line. The data instance's fall output is unused.
- The FSM, watchdog and decoder live in the top module.

## Test plan
- Reset, then frame 0x1C with parity 0 and stop 1 → `ps2_key` = 11'h61C (toggle 1, pressed 1, ext 0), one `byte_stb` with `byte_out` = 1C.
- Following frames F0, 1C → `ps2_key` = 11'h01C (toggle 0, pressed 0). No toggle occurs on the F0 byte.
- Frames E0, F0, 75 → `ps2_key` = {~t, 0, 1, 8'h75}. Then frame 16 → {t, 1, 0, 8'h16}, showing the flags were cleared.
- Frame 16 with a wrong parity bit → `frame_err` is a 1-cycle pulse and `ps2_key` is unchanged. Then E0 followed by a bad stop bit, then 75 → the event has ext = 0 (flag cleared by the error).
- 5 bits of a frame, then clock held high for TIMEOUT+10 cycles → a single `frame_err`. Then a full 2E frame → code 2E, pressed.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → no toggle. Then 16 → an event. A separate check: a 3-cycle low glitch on `ps2_clk` (FILTER_LEN 8) → no bit is shifted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
// Covers the receive FSM states, the scan-code set 2 prefixes and the ignore-list.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_CHECK
  } rx_state_e;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam logic [7:0] PS2_PAUSE     = 8'hE1;
  localparam int         PS2_PAUSE_LEN = 7;

  // Keyboard status/handshake bytes that never become key events.
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_OVERRUN = 8'h00;
  localparam logic [7:0] PS2_ERROR   = 8'hFF;

  function automatic logic is_ignored(input logic [7:0] code);
    return (code == PS2_BAT_OK) || (code == PS2_ACK)    || (code == PS2_ECHO) ||
           (code == PS2_RESEND) || (code == PS2_OVERRUN) || (code == PS2_ERROR);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-flop synchronizer followed by a run-length filter.
// The level changes only after FILTER_LEN equal samples; fall pulses for one cycle with it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN);

  logic [1:0]    sync;
  logic [CW-1:0] run_cnt;

  // NOTE: every register here is state, so all updates use <= to keep the flops
  // reading the pre-edge values of their neighbours.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync    <= 2'b11;
      level   <= 1'b1;
      run_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      fall <= 1'b0;
      if (sync[1] == level) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        level   <= sync[1];
        run_cnt <= '0;
        fall    <= ~sync[1];
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: deframes 11-bit frames and turns scan-code set 2 bytes
// into the {toggle, pressed, ext, code} ps2_key event word.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2048
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        byte_stb,
  output logic [7:0]  byte_out
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic clk_level, clk_fall, dat_level, dat_fall;
  logic unused_lines;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line    (ps2_clk),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line    (ps2_dat),
    .level   (dat_level),
    .fall    (dat_fall)
  );

  assign unused_lines = clk_level ^ dat_fall;

  rx_state_e       state_q, state_d;
  logic [3:0]      bit_cnt;
  logic [9:0]      shreg;   // {stop, parity, data[7:0]} once the frame is complete
  logic [WD_W-1:0] wd_cnt;
  logic            ext, brk;
  logic [2:0]      skip;
  logic [7:0]      byte_q;
  logic            frame_good, timeout;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    frame_good = shreg[9] & (^shreg[8:0]);
    timeout    = (state_q == RX_SHIFT) && !clk_fall && (wd_cnt == WD_W'(TIMEOUT));
    unique case (state_q)
      RX_IDLE:  if (clk_fall && !dat_level) state_d = RX_SHIFT;
      RX_SHIFT: begin
        if (clk_fall && bit_cnt == 4'd9) state_d = RX_CHECK;
        else if (timeout)                state_d = RX_IDLE;
      end
      RX_CHECK: state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
    byte_stb  = !reset && (state_q == RX_CHECK) && frame_good;
    frame_err = !reset && (((state_q == RX_CHECK) && !frame_good) || timeout);
    byte_out  = byte_stb ? shreg[7:0] : byte_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= RX_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      wd_cnt  <= '0;
      ext     <= 1'b0;
      brk     <= 1'b0;
      skip    <= '0;
      byte_q  <= '0;
      ps2_key <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RX_IDLE && clk_fall && !dat_level) begin
        bit_cnt <= '0;
        wd_cnt  <= '0;
      end else if (state_q == RX_SHIFT) begin
        if (clk_fall) begin
          shreg   <= {dat_level, shreg[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
          wd_cnt  <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end

      // Any error drops half-received prefixes so they cannot decorate a later key.
      if (frame_err) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= '0;
      end else if (byte_stb) begin
        byte_q <= shreg[7:0];
        if (skip != '0) begin
          skip <= skip - 1'b1;
        end else if (shreg[7:0] == PS2_PAUSE) begin
          skip <= 3'(PS2_PAUSE_LEN);
        end else if (shreg[7:0] == PS2_EXT) begin
          ext <= 1'b1;
        end else if (shreg[7:0] == PS2_BRK) begin
          brk <= 1'b1;
        end else if (!is_ignored(shreg[7:0])) begin
          ps2_key <= {~ps2_key[10], ~brk, ext, shreg[7:0]};
          ext     <= 1'b0;
          brk     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of frames with hand-computed event words,
// plus hand sequences for timeout, clock glitch and mid-frame reset.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2048;
  localparam int HALF_BIT   = 20;

  typedef enum {ACT_NONE, ACT_TIMEOUT, ACT_GLITCH} act_e;

  typedef struct {
    act_e        act;
    logic [7:0]  code;
    logic        bad_par;
    logic        stop;
    logic [10:0] exp_key;
    int          exp_stb;
    int          exp_err;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err, byte_stb;
  logic [7:0]  byte_out;

  int tests = 0, fails = 0;
  int stb_cnt = 0, err_cnt = 0, err_run = 0, max_err_run = 0;
  logic [7:0] last_byte = 8'h00;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .ps2_key   (ps2_key),
    .frame_err (frame_err),
    .byte_stb  (byte_stb),
    .byte_out  (byte_out)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (reset) begin
      err_run = 0;
    end else begin
      if (byte_stb) begin
        stb_cnt++;
        last_byte = byte_out;
      end
      if (frame_err) begin
        err_cnt++;
        err_run++;
        if (err_run > max_err_run) max_err_run = err_run;
      end else begin
        err_run = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic bad_par,
                                             input logic stop);
    return {stop, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int b = 0; b < n; b++) begin
      @(posedge clk_sys);
      ps2_dat = frame[b];
      repeat (HALF_BIT) @(posedge clk_sys);
      ps2_clk = 1'b0;
      repeat (HALF_BIT) @(posedge clk_sys);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    int s0, e0;

    vecs.push_back('{ACT_NONE,    8'h1C, 1'b0, 1'b1, 11'h61C, 1, 0});
    vecs.push_back('{ACT_NONE,    8'hF0, 1'b0, 1'b1, 11'h61C, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h1C, 1'b0, 1'b1, 11'h01C, 1, 0});
    vecs.push_back('{ACT_NONE,    8'hE0, 1'b0, 1'b1, 11'h01C, 1, 0});
    vecs.push_back('{ACT_NONE,    8'hF0, 1'b0, 1'b1, 11'h01C, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h75, 1'b0, 1'b1, 11'h575, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h16, 1'b0, 1'b1, 11'h216, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h16, 1'b1, 1'b1, 11'h216, 0, 1});
    vecs.push_back('{ACT_NONE,    8'hE0, 1'b0, 1'b1, 11'h216, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h75, 1'b0, 1'b0, 11'h216, 0, 1});
    vecs.push_back('{ACT_NONE,    8'h75, 1'b0, 1'b1, 11'h675, 1, 0});
    vecs.push_back('{ACT_TIMEOUT, 8'h2E, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'hE1, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h14, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h77, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'hE1, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'hF0, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h14, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'hF0, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h77, 1'b0, 1'b1, 11'h22E, 1, 0});
    vecs.push_back('{ACT_NONE,    8'h16, 1'b0, 1'b1, 11'h616, 1, 0});
    vecs.push_back('{ACT_NONE,    8'hAA, 1'b0, 1'b1, 11'h616, 1, 0});
    vecs.push_back('{ACT_GLITCH,  8'h1C, 1'b0, 1'b1, 11'h21C, 1, 0});

    repeat (5) @(posedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("reset_key",       32'(ps2_key),   32'h000);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_byte_stb",  32'(byte_stb),  32'h0);
    check("reset_byte_out",  32'(byte_out),  32'h00);
    repeat (20) @(posedge clk_sys);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].act == ACT_TIMEOUT) begin
        e0 = err_cnt;
        send_bits(make_frame(8'h2E, 1'b0, 1'b1), 5);
        repeat (TIMEOUT + 10) @(posedge clk_sys);
        @(negedge clk_sys);
        check("timeout_single_err", 32'(err_cnt - e0), 32'd1);
      end else if (vecs[i].act == ACT_GLITCH) begin
        e0 = err_cnt;
        @(posedge clk_sys);
        ps2_dat = 1'b0;
        repeat (HALF_BIT) @(posedge clk_sys);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (HALF_BIT) @(posedge clk_sys);
        ps2_dat = 1'b1;
        repeat (TIMEOUT + 50) @(posedge clk_sys);
        @(negedge clk_sys);
        check("glitch_no_start", 32'(err_cnt - e0), 32'd0);
      end
      s0 = stb_cnt;
      e0 = err_cnt;
      send_bits(make_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop), 11);
      repeat (30) @(posedge clk_sys);
      @(negedge clk_sys);
      check($sformatf("v%0d_key", i), 32'(ps2_key), 32'(vecs[i].exp_key));
      check($sformatf("v%0d_stb", i), 32'(stb_cnt - s0), 32'(vecs[i].exp_stb));
      check($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      if (vecs[i].exp_stb != 0)
        check($sformatf("v%0d_byte_out", i), 32'(last_byte), 32'(vecs[i].code));
    end

    check("err_pulse_width", 32'(max_err_run), 32'd1);

    // Reset in the middle of a frame must abandon it without an error pulse.
    e0 = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 3);
    @(posedge clk_sys);
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    reset = 1'b0;
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    check("midframe_reset_no_err", 32'(err_cnt - e0), 32'd0);
    check("midframe_reset_key",    32'(ps2_key),      32'h000);
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11);
    repeat (30) @(posedge clk_sys);
    @(negedge clk_sys);
    check("after_reset_key", 32'(ps2_key), 32'h61C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
